// File: rtl/laser_cmd_pkg.sv
// Shared constants and types for the laser command/status path:
// command codes, status frame header bytes and the TX framer state encoding.
package laser_cmd_pkg;

    localparam logic [7:0] CODE_ON    = 8'hB1;
    localparam logic [7:0] CODE_OFF   = 8'hAA;
    localparam logic [7:0] CODE_QUERY = 8'hC0;
    localparam logic [7:0] CODE_HDR0  = 8'hEB;
    localparam logic [7:0] CODE_HDR1  = 8'h90;
    localparam logic [7:0] HB_ECHO    = 8'h00;

    // State names the byte currently offered on the TX interface.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_ECHO = 3'd3,
        ST_STAT = 3'd4,
        ST_CHK  = 3'd5
    } tx_state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] echo;
    } pending_t;

endpackage

// File: rtl/laser_hb_timer.sv
// Free-running heartbeat timer: one-cycle tick every HEARTBEAT_CYCLES clocks,
// permanently low when HEARTBEAT_CYCLES is 0.
module laser_hb_timer #(
    parameter int unsigned HEARTBEAT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    generate
        if (HEARTBEAT_CYCLES == 0) begin : g_off
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign tick = 1'b0;
        end else begin : g_on
            localparam logic [31:0] LAST = 32'(HEARTBEAT_CYCLES - 1);
            logic [31:0] count_q;

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else if (count_q == LAST) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_q + 32'd1;
                end
            end

            assign tick = (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/laser_status_tx.sv
// Ack/status framer: watches received command bytes and heartbeat ticks and
// sends 5-byte frames {HDR0, HDR1, ECHO, STAT, CHK} over a valid/ready TX port.
module laser_status_tx
    import laser_cmd_pkg::*;
#(
    parameter logic [7:0]  CMD_ON           = CODE_ON,
    parameter logic [7:0]  CMD_OFF          = CODE_OFF,
    parameter logic [7:0]  CMD_QUERY        = CODE_QUERY,
    parameter logic [7:0]  HDR0             = CODE_HDR0,
    parameter logic [7:0]  HDR1             = CODE_HDR1,
    parameter int unsigned HEARTBEAT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_out_1_byte,
    input  logic       data_out_en_1_byte,
    input  logic       Laser_on_n,
    output logic [7:0] tx_data_1_byte,
    output logic       tx_data_en_1_byte,
    input  logic       tx_ready,
    output logic       frame_busy
);

    logic       hb_tick;
    logic       cmd_hit;
    logic       take;
    logic       accept;
    logic       load;
    logic [7:0] byte_d;
    logic [7:0] echo_q;
    logic [7:0] sum_q;
    pending_t   slot_q, slot_d;
    tx_state_e  state_q, state_d;

    laser_hb_timer #(
        .HEARTBEAT_CYCLES(HEARTBEAT_CYCLES)
    ) u_hb_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (hb_tick)
    );

    assign cmd_hit = data_out_en_1_byte &&
                     (data_out_1_byte inside {CMD_ON, CMD_OFF, CMD_QUERY});
    assign take    = (state_q == ST_IDLE) && slot_q.valid;
    assign accept  = tx_data_en_1_byte && tx_ready;

    // A slot being drained this cycle counts as empty, so any trigger refills it.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would infer a latch.
        slot_d = slot_q;
        if (take) begin
            slot_d.valid = 1'b0;
        end
        if (cmd_hit) begin
            slot_d = '{valid: 1'b1, echo: data_out_1_byte};
        end else if (hb_tick && !slot_d.valid) begin
            slot_d = '{valid: 1'b1, echo: HB_ECHO};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (slot_q.valid) state_d = ST_HDR0;
            ST_HDR0: if (accept)       state_d = ST_HDR1;
            ST_HDR1: if (accept)       state_d = ST_ECHO;
            ST_ECHO: if (accept)       state_d = ST_STAT;
            ST_STAT: if (accept)       state_d = ST_CHK;
            ST_CHK:  if (accept)       state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Next byte to present: loaded when a frame starts or the current byte is taken.
    always_comb begin
        load   = 1'b0;
        byte_d = tx_data_1_byte;
        case (state_q)
            ST_IDLE: if (slot_q.valid) begin load = 1'b1; byte_d = HDR0;               end
            ST_HDR0: if (accept)       begin load = 1'b1; byte_d = HDR1;               end
            ST_HDR1: if (accept)       begin load = 1'b1; byte_d = echo_q;             end
            ST_ECHO: if (accept)       begin load = 1'b1; byte_d = {7'b0, ~Laser_on_n}; end
            ST_STAT: if (accept)       begin load = 1'b1; byte_d = sum_q;              end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_1_byte    <= '0;
            tx_data_en_1_byte <= 1'b0;
            echo_q            <= '0;
            sum_q             <= '0;
        end else begin
            if (take) begin
                echo_q <= slot_q.echo;
            end
            if (load) begin
                tx_data_1_byte <= byte_d;
                sum_q          <= (state_q == ST_IDLE) ? byte_d : sum_q + byte_d;
            end
            if (take) begin
                tx_data_en_1_byte <= 1'b1;
            end else if (state_q == ST_CHK && accept) begin
                tx_data_en_1_byte <= 1'b0;
            end
        end
    end

    assign frame_busy = tx_data_en_1_byte;

endmodule

// File: tb/tb_laser_status_tx.sv
// Directed bench for laser_status_tx: ack frames, stalls, slot overwrite,
// heartbeat timing (second instance, 16-cycle period) and async reset abort.
module tb_laser_status_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_en = 1'b0;
    logic       laser_on_n = 1'b1;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       busy;

    logic [7:0] hb_rx_byte = 8'h00;
    logic       hb_rx_en = 1'b0;
    logic       hb_tx_ready = 1'b1;
    logic [7:0] hb_tx_data;
    logic       hb_tx_en;
    logic       hb_busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] got [5];
    int got_n;

    always #5 clk = ~clk;

    laser_status_tx #(.HEARTBEAT_CYCLES(0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .data_out_1_byte   (rx_byte),
        .data_out_en_1_byte(rx_en),
        .Laser_on_n        (laser_on_n),
        .tx_data_1_byte    (tx_data),
        .tx_data_en_1_byte (tx_en),
        .tx_ready          (tx_ready),
        .frame_busy        (busy)
    );

    laser_status_tx #(.HEARTBEAT_CYCLES(16)) dut_hb (
        .clk               (clk),
        .rst_n             (rst_n),
        .data_out_1_byte   (hb_rx_byte),
        .data_out_en_1_byte(hb_rx_en),
        .Laser_on_n        (laser_on_n),
        .tx_data_1_byte    (hb_tx_data),
        .tx_data_en_1_byte (hb_tx_en),
        .tx_ready          (hb_tx_ready),
        .frame_busy        (hb_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input bit hb, input logic [7:0] b);
        if (hb) begin hb_rx_byte = b; hb_rx_en = 1'b1; end
        else    begin rx_byte = b;    rx_en = 1'b1;    end
        step();
        hb_rx_en = 1'b0;
        rx_en    = 1'b0;
    endtask

    // Current cycle must present HDR0; checks five consecutive bytes at full rate.
    task automatic expect_stream(input string tag, input bit hb, input logic [39:0] exp);
        for (int i = 0; i < 5; i++) begin
            check({tag, "_en"}, hb ? hb_tx_en : tx_en, 1'b1);
            check({tag, "_busy"}, hb ? hb_busy : busy, 1'b1);
            check({tag, "_byte"}, hb ? hb_tx_data : tx_data, exp[39-8*i -: 8]);
            step();
        end
        check({tag, "_end_en"}, hb ? hb_tx_en : tx_en, 1'b0);
        check({tag, "_end_busy"}, hb ? hb_busy : busy, 1'b0);
    endtask

    task automatic idle_for(input string tag, input bit hb, input int n);
        int hi = 0;
        for (int i = 0; i < n; i++) begin
            if ((hb ? hb_tx_en : tx_en) !== 1'b0) hi++;
            step();
        end
        check(tag, hi, 0);
    endtask

    // Accepts one frame from the main DUT; stall_mod>0 raises tx_ready 1 cycle in stall_mod.
    task automatic collect(input string tag, input int stall_mod);
        logic [7:0] held = 8'h00;
        bit held_valid = 1'b0;
        got_n = 0;
        for (int c = 0; c < 64 && got_n < 5; c++) begin
            tx_ready = (stall_mod == 0) ? 1'b1 : ((c % stall_mod) == stall_mod - 1);
            if (held_valid) check({tag, "_hold"}, {tx_en, tx_data}, {1'b1, held});
            if (tx_en) begin
                if (tx_ready) begin
                    got[got_n] = tx_data;
                    got_n++;
                    held_valid = 1'b0;
                end else begin
                    held = tx_data;
                    held_valid = 1'b1;
                end
            end
            step();
        end
        tx_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [39:0] exp);
        check({tag, "_count"}, got_n, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_n) check({tag, "_byte"}, got[i], exp[39-8*i -: 8]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c;

        // Reset state
        #1;
        check("rst_data", tx_data, 8'h00);
        check("rst_en", tx_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        idle_for("rst_idle", 1'b0, 3);

        // 1: laser off, B1 ack; decoder turns the laser on 2 clks after the strobe
        laser_on_n = 1'b1;
        tx_ready   = 1'b1;
        check("t1_n_en", tx_en, 1'b0);
        strobe(1'b0, 8'hB1);
        check("t1_n1_en", tx_en, 1'b0);
        step();
        laser_on_n = 1'b0;
        expect_stream("t1", 1'b0, 40'hEB_90_B1_01_2D);

        // 2: laser on, AA ack; laser goes off 2 clks after the strobe
        strobe(1'b0, 8'hAA);
        check("t2_n1_en", tx_en, 1'b0);
        step();
        laser_on_n = 1'b1;
        expect_stream("t2", 1'b0, 40'hEB_90_AA_00_25);

        // 3: query with tx_ready high one cycle in three
        laser_on_n = 1'b0;
        strobe(1'b0, 8'hC0);
        collect("t3", 3);
        check_frame("t3", 40'hEB_90_C0_01_3C);
        check("t3_done_en", tx_en, 1'b0);

        // 4: B1 then AA while a frame is stalled; latest wins, one extra frame
        tx_ready = 1'b0;
        strobe(1'b0, 8'hC0);
        step();
        check("t4_hdr0_en", tx_en, 1'b1);
        strobe(1'b0, 8'hB1);
        strobe(1'b0, 8'hAA);
        check("t4_stall_data", tx_data, 8'hEB);
        collect("t4a", 0);
        check_frame("t4a", 40'hEB_90_C0_01_3C);
        check("t4_gap_en", tx_en, 1'b0);
        collect("t4b", 0);
        check_frame("t4b", 40'hEB_90_AA_01_26);
        idle_for("t4_no_more", 1'b0, 10);
        strobe(1'b0, 8'h55);
        idle_for("t4_ignore55", 1'b0, 10);

        // 5: heartbeat every 16 clks, laser off; tick coincident with C0
        rst_n = 1'b0;
        laser_on_n = 1'b1;
        hb_tx_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        c = 0;
        while (c < 40 && hb_tx_en !== 1'b1) begin
            step();
            c++;
        end
        check("t5_first_start", c, 17);
        expect_stream("t5_hb0", 1'b1, 40'hEB_90_00_00_7B);
        idle_for("t5_gap0", 1'b1, 11);
        expect_stream("t5_hb1", 1'b1, 40'hEB_90_00_00_7B);
        idle_for("t5_gap1", 1'b1, 9);
        strobe(1'b1, 8'hC0);
        check("t5_c0_n1_en", hb_tx_en, 1'b0);
        step();
        expect_stream("t5_c0", 1'b1, 40'hEB_90_C0_00_3B);
        idle_for("t5_dropped_tick", 1'b1, 11);
        expect_stream("t5_hb2", 1'b1, 40'hEB_90_00_00_7B);

        // 6: async reset during ECHO aborts the frame for good
        tx_ready = 1'b1;
        laser_on_n = 1'b0;
        strobe(1'b0, 8'hB1);
        step();
        step();
        step();
        check("t6_echo", tx_data, 8'hB1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", tx_data, 8'h00);
        check("t6_rst_en", tx_en, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        idle_for("t6_no_resume", 1'b0, 10);
        check("t6_idle_busy", busy, 1'b0);
        strobe(1'b0, 8'hC0);
        check("t6_n1_en", tx_en, 1'b0);
        step();
        expect_stream("t6_new", 1'b0, 40'hEB_90_C0_01_3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
